sw_port_fsm_mp: RTL

//  Packet-aware input controller for the switch: parses framed packets from one byte stream and routes

---
 rtl/sw_pkg.sv | 22 ++
 rtl/sw_addr_decode.sv | 30 +++
 rtl/sw_port_fsm_mp.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared types and limits for the multi-port packet input controller.
package sw_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    PARITY,
    DISCARD
  } sw_state_e;

  // Position inside a packet that is being parsed but not written.
  typedef enum logic [1:0] {
    DP_LEN,
    DP_DATA,
    DP_PARITY
  } disc_phase_e;

endpackage

// File: rtl/sw_addr_decode.sv
// Combinational address match against all port addresses; lowest matching port wins.
module sw_addr_decode
  import sw_pkg::*;
#(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [W_WIDTH-1:0]           data_in,
  input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]         port_busy,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic                         hit_busy
);

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_busy = 1'b0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (data_in == port_addr[p*W_WIDTH +: W_WIDTH]) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(p);
        hit_busy = port_busy[p];
      end
    end
  end

endmodule

// File: rtl/sw_port_fsm_mp.sv
// Length-framed packet router: steers each whole packet to one of NUM_PORTS FIFOs, drops busy targets.
// Optional parity checking is enabled with the PARITY_CHECK_EN macro.
module sw_port_fsm_mp
  import sw_pkg::*;
#(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sw_en,
  input  logic [W_WIDTH-1:0]           data_in,
  input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]         port_busy,
  output logic [NUM_PORTS-1:0]         wr_en,
  output logic [W_WIDTH-1:0]           data_out,
  output logic                         pkt_done,
  output logic                         pkt_drop,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         pkt_err
);

  logic             hit;
  logic             hit_busy;
  logic [IDX_W-1:0] hit_idx;

  sw_addr_decode #(
    .W_WIDTH   (W_WIDTH),
    .NUM_PORTS (NUM_PORTS)
  ) u_addr_decode (
    .data_in   (data_in),
    .port_addr (port_addr),
    .port_busy (port_busy),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_busy  (hit_busy)
  );

  sw_state_e            state_q, state_d;
  disc_phase_e          phase_q, phase_d;
  logic [W_WIDTH-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [NUM_PORTS-1:0] wr_en_q, wr_en_d;
  logic [W_WIDTH-1:0]   data_out_q, data_out_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 pkt_drop_q, pkt_drop_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [IDX_W-1:0]     wr_sel;
  logic                 do_wr;
`ifdef PARITY_CHECK_EN
  logic [W_WIDTH-1:0]   xor_q, xor_d;
  logic                 pkt_err_q, pkt_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    wr_sel     = sel_q;
    do_wr      = 1'b0;
    data_out_d = data_out_q;
    pkt_done_d = 1'b0;
    pkt_drop_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
`ifdef PARITY_CHECK_EN
    xor_d      = xor_q;
    pkt_err_d  = 1'b0;
`endif
    if (sw_en) begin
      unique case (state_q)
        IDLE: begin
`ifdef PARITY_CHECK_EN
          xor_d = data_in;
`endif
          if (hit && !hit_busy) begin
            sel_d   = hit_idx;
            wr_sel  = hit_idx;
            do_wr   = 1'b1;
            state_d = LEN;
          end else begin
            if (hit) begin
              pkt_drop_d = 1'b1;
              if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            phase_d = DP_LEN;
            state_d = DISCARD;
          end
        end
        LEN: begin
          do_wr   = 1'b1;
          rem_d   = data_in;
          state_d = (data_in == '0) ? PARITY : DATA;
`ifdef PARITY_CHECK_EN
          xor_d   = xor_q ^ data_in;
`endif
        end
        DATA: begin
          do_wr = 1'b1;
          rem_d = rem_q - W_WIDTH'(1);
          if (rem_q == W_WIDTH'(1)) state_d = PARITY;
`ifdef PARITY_CHECK_EN
          xor_d = xor_q ^ data_in;
`endif
        end
        PARITY: begin
          do_wr      = 1'b1;
          pkt_done_d = 1'b1;
          state_d    = IDLE;
`ifdef PARITY_CHECK_EN
          pkt_err_d  = (xor_q != data_in);
`endif
        end
        DISCARD: begin
          unique case (phase_q)
            DP_LEN: begin
              rem_d   = data_in;
              phase_d = (data_in == '0) ? DP_PARITY : DP_DATA;
            end
            DP_DATA: begin
              rem_d = rem_q - W_WIDTH'(1);
              if (rem_q == W_WIDTH'(1)) phase_d = DP_PARITY;
            end
            default: state_d = IDLE;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PARITY_CHECK_EN
    else if (state_q == IDLE) begin
      xor_d = '0;
    end
`endif
    if (do_wr) data_out_d = data_in;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_en_d[p] = do_wr && (wr_sel == IDX_W'(p));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= DP_LEN;
      rem_q      <= '0;
      sel_q      <= '0;
      wr_en_q    <= '0;
      data_out_q <= '0;
      pkt_done_q <= 1'b0;
      pkt_drop_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef PARITY_CHECK_EN
      xor_q      <= '0;
      pkt_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      wr_en_q    <= wr_en_d;
      data_out_q <= data_out_d;
      pkt_done_q <= pkt_done_d;
      pkt_drop_q <= pkt_drop_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef PARITY_CHECK_EN
      xor_q      <= xor_d;
      pkt_err_q  <= pkt_err_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign data_out = data_out_q;
  assign pkt_done = pkt_done_q;
  assign pkt_drop = pkt_drop_q;
  assign drop_cnt = drop_cnt_q;
`ifdef PARITY_CHECK_EN
  assign pkt_err  = pkt_err_q;
`else
  assign pkt_err  = 1'b0;
`endif

endmodule
